frac_divider_mash_gen: RTL and testbench
========================================

Name: frac_divider_mash_gen

Overview:
- Parametrised successor of the fractional divider. It divides in_clk by an average ratio of INT + FRAC/2^FRAC_W.
- Uses a synchronous reload down-counter instead of a 2/3 prescaler chain. Period ratio N = INT + c, where c comes from a MASH 1-1-1 delta-sigma core of runtime-selectable order (1, 2 or 3).
- Adds a valid/ready config handshake with glitch-free application at period boundaries, an enable with clean stop, and ratio saturation with a sticky flag.
- Sits between the register interface and the PLL feedback path.

Parameters:
- INT_W, 8, width of integer ratio and period counter
- FRAC_W, 16, width of fractional word and of each accumulator
- MIN_DIV, 4, smallest period ratio ever issued (2 <= MIN_DIV < 2^INT_W)

Ports:
- in_clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accept; transfer happens when cfg_valid && cfg_ready
- cfg_int  in  INT_W  integer part INT
- cfg_frac  in  FRAC_W  fractional part FRAC
- cfg_order  in  2  MASH order: 1, 2, 3; 0 is treated as 1
- enable  in  1  run request
- out_clk  out  1  divided clock, registered
- out_pulse  out  1  one-cycle tick on the last in_clk cycle of each period
- div_cur  out  INT_W  N of the period in progress
- sat  out  1  sticky: some N was clamped since the last accepted config

Behaviour:
- Reset (rst=0, async) clears everything: state=IDLE; count, all accumulators and delay registers = 0; applied/pending config = 0; cfg_loaded=0; out_clk=0; out_pulse=0; div_cur=0; sat=0; cfg_ready=1.
- States:
  - IDLE to RUN on an edge where enable=1 and cfg_loaded=1 (a load edge).
  - RUN to IDLE on the edge where count==0 and enable=0. The current period always completes.
- Config handshake:
  - In IDLE, cfg_ready=1. An accepted config is written straight to the applied registers and sets cfg_loaded.
  - In RUN, an accepted config goes to a pending register and cfg_ready drops to 0 the next cycle.
  - Pending config is copied to applied on the next load edge and is used by that same load. cfg_ready returns to 1 the cycle after.
  - An accept clears sat.
- Load edge (IDLE to RUN, or RUN with count==0 and enable=1):
  - count <= N-1; div_cur <= N; MASH registers step once.
  - N is computed combinationally from the applied (or just-applied) INT and order and the current MASH state.
- MASH core (FRAC_W-bit accumulators acc1..acc3, carries k1..k3):
  - acc1 += FRAC; acc2 += acc1_next; acc3 += acc2_next.
  - order1: c = k1.
  - order2: c = k1 + k2 - k2_d.
  - order3: c = k1 + (k2 - k2_d) + (k3 - 2*k3_d + k3_dd).
  - c is signed 4-bit; ranges are order1 0..1, order2 -1..2, order3 -3..4.
  - A change of order on apply clears acc1..acc3 and all delays. A FRAC-only change keeps state.
- Ratio arithmetic:
  - N = INT + c, evaluated in INT_W+2 signed bits.
  - N < MIN_DIV clamps to MIN_DIV; N > 2^INT_W-1 clamps to 2^INT_W-1. Either clamp sets sat.
- Counter: in RUN, counts down N-1 to 0; every period is exactly N in_clk cycles.
- out_clk:
  - Registered; 1 while count >= floor(N/2), giving ceil(N/2) high cycles per period.
  - Rises on the load edge (first high cycle is 1 cycle after enable is sampled).
  - Forced 0 in IDLE.
- out_pulse = 1 during the count==0 cycle in RUN; 0 otherwise.
- enable has no effect mid-period. Deasserting and reasserting within one period does not stop the divider.
- MASH state is frozen in IDLE and resumes from its held state on restart. Only an order change or reset clears it.

Test Plan:
- INT=8, FRAC=0, order=1, enable=1 -> out_clk period 8 cycles, high 4, out_pulse every 8th cycle, div_cur=8, sat=0.
- INT=8, FRAC=0x8000, order=1 -> period sequence 8,9,8,9...; div_cur follows it.
- INT=8, FRAC=0x4000, order=3, 4096 periods -> for every k, |sum of N over first k periods - 8.25k| <= 3; each N in 5..12.
- INT=4, FRAC=0x2000, order=3 with MIN_DIV=4 -> no N below 4 issued, sat=1; sat clears on the next accepted config.
- While running INT=8: offer INT=12 mid-period -> cfg_ready drops; current period stays 8 cycles; next period 12; cfg_ready back to 1 the following cycle.
- Drop enable mid-period, then assert rst=0 asynchronously mid-period in a second run -> period completes then out_clk=0 and state IDLE; on reset all outputs go to reset values immediately, with no further out_pulse.

Source files
------------

// File: rtl/frac_divider_mash_gen.sv
// frac_divider_mash_gen
//   Fractional clock divider for the PLL feedback path. Divides in_clk by an
//   average ratio of INT + FRAC/2^FRAC_W. Each output period lasts N = INT + c
//   in_clk cycles. A reload down-counter produces the period. The correction c
//   comes from a MASH 1-1-1 delta-sigma core whose order (1..3) is chosen at
//   runtime.
//
// Ports
//   in_clk     single clock
//   rst        asynchronous active-low reset
//   cfg_valid  config offer
//   cfg_ready  config accept; a transfer happens when cfg_valid && cfg_ready
//   cfg_int    integer ratio INT
//   cfg_frac   fractional ratio FRAC
//   cfg_order  MASH order 1..3 (0 behaves as 1)
//   enable     run request; it is sampled only at period boundaries
//   out_clk    divided clock (registered); high for ceil(N/2) cycles
//   out_pulse  high during the last in_clk cycle of every period
//   div_cur    N of the period in progress
//   sat        sticky; some N was clamped since the last accepted config
module frac_divider_mash_gen #(
    parameter int INT_W   = 8,
    parameter int FRAC_W  = 16,
    parameter int MIN_DIV = 4
) (
    input  logic              in_clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic [1:0]        cfg_order,
    input  logic              enable,
    output logic              out_clk,
    output logic              out_pulse,
    output logic [INT_W-1:0]  div_cur,
    output logic              sat
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Two extra bits keep INT + c exact: there is room for the sign bit and
    // for an overflow above 2^INT_W-1.
    localparam int NW = INT_W + 2;
    localparam logic signed [NW-1:0] N_MIN = NW'(MIN_DIV);
    localparam logic signed [NW-1:0] N_MAX = NW'((1 << INT_W) - 1);

    logic [0:0]        state;
    logic [INT_W-1:0]  count;
    logic [FRAC_W-1:0] acc1, acc2, acc3;
    logic              k2_d, k3_d, k3_dd;

    logic [INT_W-1:0]  app_int,  pend_int;
    logic [FRAC_W-1:0] app_frac, pend_frac;
    logic [1:0]        app_order, pend_order;
    logic              pend_valid, cfg_loaded;

    // ---------------------------------------------------------------- control
    logic       accept, period_end, load_edge, stop_edge, pend_take, direct;
    logic [1:0] cfg_order_n;

    assign cfg_ready   = !pend_valid;
    assign accept      = cfg_valid && cfg_ready;
    assign cfg_order_n = (cfg_order == 2'd0) ? 2'd1 : cfg_order;
    assign period_end  = (state == ST_RUN) && (count == '0);
    assign load_edge   = ((state == ST_IDLE) && enable && cfg_loaded) ||
                         (period_end && enable);
    assign stop_edge   = period_end && !enable;
    // When a period ends and the divider stops, a config can be applied
    // immediately. There is then no reason to park it in the pending register.
    assign pend_take   = accept && (state == ST_RUN) && !stop_edge;
    assign direct      = accept && !pend_take;
    assign out_pulse   = period_end;

    // Config used on this edge: a direct accept, a pending config being
    // applied, or the config that is already applied.
    logic [INT_W-1:0]  eff_int;
    logic [FRAC_W-1:0] eff_frac;
    logic [1:0]        eff_order;
    logic              apply, clear_mash;

    always_comb begin
        // NOTE: every variable gets a default before the branches. Without it,
        //       a path that skips an assignment would infer a latch.
        eff_int   = app_int;
        eff_frac  = app_frac;
        eff_order = app_order;
        apply     = 1'b0;
        if (direct) begin
            eff_int   = cfg_int;
            eff_frac  = cfg_frac;
            eff_order = cfg_order_n;
            apply     = 1'b1;
        end else if (pend_valid && (load_edge || stop_edge)) begin
            eff_int   = pend_int;
            eff_frac  = pend_frac;
            eff_order = pend_order;
            apply     = 1'b1;
        end
        clear_mash = apply && (eff_order != app_order);
    end

    // ------------------------------------------------------------- MASH core
    // The core steps from the cleared state when this same edge changes the
    // order. The new order therefore starts from zero.
    logic [FRAC_W-1:0] a1_b, a2_b, a3_b, s1, s2, s3;
    logic              k2_db, k3_db, k3_ddb, k1, k2, k3;
    logic signed [3:0] t1, t2, t3, c;

    assign a1_b   = clear_mash ? '0 : acc1;
    assign a2_b   = clear_mash ? '0 : acc2;
    assign a3_b   = clear_mash ? '0 : acc3;
    assign k2_db  = clear_mash ? 1'b0 : k2_d;
    assign k3_db  = clear_mash ? 1'b0 : k3_d;
    assign k3_ddb = clear_mash ? 1'b0 : k3_dd;

    assign {k1, s1} = {1'b0, a1_b} + {1'b0, eff_frac};
    assign {k2, s2} = {1'b0, a2_b} + {1'b0, s1};
    assign {k3, s3} = {1'b0, a3_b} + {1'b0, s2};

    assign t1 = $signed({3'b000, k1});
    assign t2 = $signed({3'b000, k2}) - $signed({3'b000, k2_db});
    assign t3 = $signed({3'b000, k3}) - $signed({2'b00, k3_db, 1'b0}) +
                $signed({3'b000, k3_ddb});

    always_comb begin
        case (eff_order)
            2'd2:    c = t1 + t2;
            2'd3:    c = t1 + t2 + t3;
            default: c = t1;
        endcase
    end

    // ----------------------------------------------------- ratio arithmetic
    logic signed [NW-1:0] n_raw;
    logic [INT_W-1:0]     n_val, n_dec, count_dec;
    logic                 clamp;

    assign n_raw = $signed({2'b00, eff_int}) + $signed({{(NW-4){c[3]}}, c});

    always_comb begin
        clamp = 1'b0;
        n_val = n_raw[INT_W-1:0];
        if (n_raw < N_MIN) begin
            clamp = 1'b1;
            n_val = N_MIN[INT_W-1:0];
        end else if (n_raw > N_MAX) begin
            clamp = 1'b1;
            n_val = N_MAX[INT_W-1:0];
        end
    end

    assign n_dec     = n_val - INT_W'(1);
    assign count_dec = count - INT_W'(1);

    // ------------------------------------------------------------ registers
    // NOTE: all state below uses non-blocking assignments. Every register then
    //       sees the values from before the edge, whatever order the
    //       statements are written in.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            acc1       <= '0;
            acc2       <= '0;
            acc3       <= '0;
            k2_d       <= 1'b0;
            k3_d       <= 1'b0;
            k3_dd      <= 1'b0;
            app_int    <= '0;
            app_frac   <= '0;
            app_order  <= '0;
            pend_int   <= '0;
            pend_frac  <= '0;
            pend_order <= '0;
            pend_valid <= 1'b0;
            cfg_loaded <= 1'b0;
            out_clk    <= 1'b0;
            div_cur    <= '0;
            sat        <= 1'b0;
        end else begin
            if (apply) begin
                app_int    <= eff_int;
                app_frac   <= eff_frac;
                app_order  <= eff_order;
                cfg_loaded <= 1'b1;
            end

            if (pend_take) begin
                pend_int   <= cfg_int;
                pend_frac  <= cfg_frac;
                pend_order <= cfg_order_n;
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end

            if (load_edge && clamp) sat <= 1'b1;
            else if (accept)        sat <= 1'b0;

            // The MASH state is held in IDLE. It advances only on a load edge.
            if (load_edge) begin
                acc1  <= s1;
                acc2  <= s2;
                acc3  <= s3;
                k2_d  <= k2;
                k3_d  <= k3;
                k3_dd <= k3_db;
            end else if (clear_mash) begin
                acc1  <= '0;
                acc2  <= '0;
                acc3  <= '0;
                k2_d  <= 1'b0;
                k3_d  <= 1'b0;
                k3_dd <= 1'b0;
            end

            if (load_edge) begin
                state   <= ST_RUN;
                count   <= n_dec;
                div_cur <= n_val;
                out_clk <= (n_dec >= (n_val >> 1));
            end else if (state == ST_RUN && count != '0) begin
                count   <= count_dec;
                out_clk <= (count_dec >= (div_cur >> 1));
            end else begin
                // This branch covers the stop edge and idle cycles.
                state   <= ST_IDLE;
                count   <= '0;
                out_clk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frac_divider_mash_gen.sv
// Directed bench for frac_divider_mash_gen using the default parameters
// (INT_W=8, FRAC_W=16, MIN_DIV=4). A table of configurations with hand-derived
// period sequences is followed by sequences for reconfiguration, long-run
// order-3 averaging, saturation, stop and asynchronous reset.
module tb_frac_divider_mash_gen;

    logic        in_clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_int = '0;
    logic [15:0] cfg_frac = '0;
    logic [1:0]  cfg_order = '0;
    logic        enable = 1'b0;
    logic        out_clk, out_pulse, sat;
    logic [7:0]  div_cur;

    int n_cmp = 0;
    int n_fail = 0;

    frac_divider_mash_gen dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_int   (cfg_int),
        .cfg_frac  (cfg_frac),
        .cfg_order (cfg_order),
        .enable    (enable),
        .out_clk   (out_clk),
        .out_pulse (out_pulse),
        .div_cur   (div_cur),
        .sat       (sat)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  i;
        logic [15:0] f;
        logic [1:0]  o;
        int          p0, p1, p2, p3;
        bit          s;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_valid = 1'b0;
        enable    = 1'b0;
        rst       = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic offer(input logic [7:0] i, input logic [15:0] f,
                         input logic [1:0] o);
        cfg_int   = i;
        cfg_frac  = f;
        cfg_order = o;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Counts cycles up to and including the next out_pulse sample.
    // n0 is the number of cycles of this period that have already been seen.
    task automatic get_period(input int n0, output int n, output int hi,
                              output int dc);
        bit ok = 1'b0;
        n  = n0;
        hi = 0;
        dc = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            n++;
            hi += int'(out_clk);
            if (out_pulse) begin
                dc = int'(div_cur);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL period_timeout: no out_pulse within 600 cycles");
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   n, hi, dc, ep[4];
        int   sum, bad_range, bad_err, bad_dc, min_n, quiet_bad;
        int   err;

        vecs[0] = '{8'd8,   16'h0000, 2'd1, 8, 8, 8, 8, 1'b0};
        vecs[1] = '{8'd8,   16'h8000, 2'd1, 8, 9, 8, 9, 1'b0};
        vecs[2] = '{8'd10,  16'h4000, 2'd1, 10, 10, 10, 11, 1'b0};
        vecs[3] = '{8'd8,   16'h8000, 2'd0, 8, 9, 8, 9, 1'b0};
        vecs[4] = '{8'd8,   16'h8000, 2'd2, 8, 9, 9, 8, 1'b0};
        vecs[5] = '{8'd2,   16'h0000, 2'd1, 4, 4, 4, 4, 1'b1};
        vecs[6] = '{8'd255, 16'h8000, 2'd1, 255, 255, 255, 255, 1'b1};
        vecs[7] = '{8'd5,   16'hFFFF, 2'd1, 5, 6, 6, 6, 1'b0};

        // Reset values while rst is held low.
        tick();
        check("rst_out_clk", out_clk, 0);
        check("rst_out_pulse", out_pulse, 0);
        check("rst_div_cur", div_cur, 0);
        check("rst_sat", sat, 0);
        check("rst_cfg_ready", cfg_ready, 1);

        // Table of configurations, each started from reset.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            offer(vecs[v].i, vecs[v].f, vecs[v].o);
            enable = 1'b1;
            ep = '{vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3};
            for (int p = 0; p < 4; p++) begin
                get_period(0, n, hi, dc);
                check($sformatf("v%0d_period%0d", v, p), n, ep[p]);
                check($sformatf("v%0d_div_cur%0d", v, p), dc, ep[p]);
                check($sformatf("v%0d_high%0d", v, p), hi, (ep[p] + 1) / 2);
            end
            check($sformatf("v%0d_sat", v), sat, vecs[v].s);
        end

        // Reconfiguration in the middle of a period.
        do_reset();
        offer(8'd8, 16'h0000, 2'd1);
        enable = 1'b1;
        get_period(0, n, hi, dc);
        tick();
        tick();
        tick();
        cfg_int   = 8'd12;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("mid_cfg_ready_low", cfg_ready, 0);
        get_period(4, n, hi, dc);
        check("mid_cur_period", n, 8);
        check("mid_cur_div", dc, 8);
        tick();
        check("mid_cfg_ready_back", cfg_ready, 1);
        check("mid_next_div", div_cur, 12);
        get_period(1, n, hi, dc);
        check("mid_next_period", n, 12);

        // Order 3, INT=8, FRAC=1/4: each N stays in range and the running sum
        // stays within 3 of 8.25k.
        do_reset();
        offer(8'd8, 16'h4000, 2'd3);
        enable = 1'b1;
        sum = 0;
        bad_range = 0;
        bad_err = 0;
        bad_dc = 0;
        for (int k = 1; k <= 4096; k++) begin
            get_period(0, n, hi, dc);
            sum += n;
            if (n < 5 || n > 12) bad_range++;
            if (n != dc) bad_dc++;
            err = 4 * sum - 33 * k;
            if (err > 12 || err < -12) bad_err++;
        end
        check("o3_range_violations", bad_range, 0);
        check("o3_avg_violations", bad_err, 0);
        check("o3_div_cur_violations", bad_dc, 0);
        check("o3_sum", sum, 33792);
        check("o3_sat", sat, 0);

        // Saturation against MIN_DIV, then cleared by an accepted config.
        do_reset();
        offer(8'd4, 16'h2000, 2'd3);
        enable = 1'b1;
        min_n = 999;
        for (int k = 0; k < 64; k++) begin
            get_period(0, n, hi, dc);
            if (n < min_n) min_n = n;
        end
        check("sat_min_period", min_n, 4);
        check("sat_set", sat, 1);
        tick();
        tick();
        offer(8'd8, 16'h0000, 2'd3);
        check("sat_cleared", sat, 0);
        check("sat_cfg_pending", cfg_ready, 0);

        // A short enable glitch does not stop the divider; a real drop stops it
        // cleanly at the end of the period.
        do_reset();
        offer(8'd8, 16'h0000, 2'd1);
        enable = 1'b1;
        get_period(0, n, hi, dc);
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        get_period(4, n, hi, dc);
        check("glitch_period", n, 8);
        get_period(0, n, hi, dc);
        check("glitch_keeps_running", n, 8);
        tick();
        tick();
        tick();
        enable = 1'b0;
        get_period(3, n, hi, dc);
        check("stop_period_completes", n, 8);
        quiet_bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_clk !== 1'b0 || out_pulse !== 1'b0) quiet_bad++;
        end
        check("stop_idle_quiet", quiet_bad, 0);
        check("stop_cfg_ready", cfg_ready, 1);

        // Restart keeps the config. Then apply an asynchronous reset mid-period.
        enable = 1'b1;
        get_period(0, n, hi, dc);
        check("restart_period", n, 8);
        tick();
        tick();
        tick();
        #3;
        rst = 1'b0;
        #1;
        check("arst_out_clk", out_clk, 0);
        check("arst_out_pulse", out_pulse, 0);
        check("arst_div_cur", div_cur, 0);
        check("arst_sat", sat, 0);
        check("arst_cfg_ready", cfg_ready, 1);
        tick();
        rst = 1'b1;
        quiet_bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_clk !== 1'b0 || out_pulse !== 1'b0) quiet_bad++;
        end
        check("arst_no_pulse", quiet_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
